// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline sequencer: state encodings, drain
// length and well-known instruction/register constants.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_DRAIN = 2'b11
  } state_t;

  // Cycles needed to empty EX, MEM and WB once HALT has left ID.
  localparam int DRAIN_CYCLES = 3;

  // Opcode field value decoded as HALT by the ID stage.
  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  // Register r0 is hard-wired to zero, so writes to it never create a hazard.
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard detection between the load in EX and the
// instruction currently being decoded in ID.
module load_use_detector
  import pipeline_pkg::*;
#(
  parameter int NB_ADDR = 5
) (
  input  logic               i_ex_data_mem_rd_enb,
  input  logic [NB_ADDR-1:0] i_ex_rf_wr_addr,
  input  logic [NB_ADDR-1:0] i_id_rs_addr,
  input  logic [NB_ADDR-1:0] i_id_rt_addr,
  input  logic               i_id_uses_rt,
  output logic               o_hazard
);

  logic w_dst_valid;
  logic w_rs_match;
  logic w_rt_match;

  assign w_dst_valid = (i_ex_rf_wr_addr != NB_ADDR'(REG_ZERO));
  assign w_rs_match  = (i_ex_rf_wr_addr == i_id_rs_addr);
  assign w_rt_match  = i_id_uses_rt & (i_ex_rf_wr_addr == i_id_rt_addr);
  assign o_hazard    = i_ex_data_mem_rd_enb & w_dst_valid & (w_rs_match | w_rt_match);

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/step/halt controller and hazard sequencer for the 5-stage pipeline.
// Produces latch/PC enables, load-use bubbles, branch flushes and the
// HALT drain sequence, and counts advancing cycles for debug.
module pipeline_sequencer
  import pipeline_pkg::*;
#(
  parameter int NB_ADDR      = 5,
  parameter int NB_CYCLE_CNT = 32,
  parameter int NB_DRAIN     = 2,
  parameter int DRAIN_CYCLES = pipeline_pkg::DRAIN_CYCLES
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic                    i_run,
  input  logic                    i_step,
  input  logic                    i_halt_req,
  input  logic                    i_id_halt_inst,
  input  logic [NB_ADDR-1:0]      i_id_rs_addr,
  input  logic [NB_ADDR-1:0]      i_id_rt_addr,
  input  logic                    i_id_uses_rt,
  input  logic                    i_ex_data_mem_rd_enb,
  input  logic [NB_ADDR-1:0]      i_ex_rf_wr_addr,
  input  logic                    i_mem_branch_taken,
  output logic                    o_pc_enb,
  output logic                    o_if_id_enb,
  output logic                    o_pipe_enb,
  output logic                    o_id_ex_bubble,
  output logic                    o_flush_if_id,
  output logic                    o_flush_id_ex,
  output logic                    o_flush_ex_mem,
  output logic [1:0]              o_state,
  output logic                    o_halted,
  output logic [NB_CYCLE_CNT-1:0] o_cycle_count
);

  state_t                  r_state;
  logic                    r_halted;
  logic [NB_CYCLE_CNT-1:0] r_cycle_count;
  logic [NB_DRAIN-1:0]     r_drain_cnt;
  logic                    r_resume_run;

  logic w_hz;
  logic w_adv;
  logic w_drain;
  logic w_branch;
  logic w_stall;
  logic w_halt_go;

  load_use_detector #(
    .NB_ADDR (NB_ADDR)
  ) u_load_use_detector (
    .i_ex_data_mem_rd_enb (i_ex_data_mem_rd_enb),
    .i_ex_rf_wr_addr      (i_ex_rf_wr_addr),
    .i_id_rs_addr         (i_id_rs_addr),
    .i_id_rt_addr         (i_id_rt_addr),
    .i_id_uses_rt         (i_id_uses_rt),
    .o_hazard             (w_hz)
  );

  assign w_adv    = (r_state != ST_IDLE);
  assign w_drain  = (r_state == ST_DRAIN);
  // A taken branch overrides a coincident load-use stall: the stalled
  // instruction is on the wrong path and is flushed anyway.
  assign w_branch = w_adv & i_mem_branch_taken;
  assign w_stall  = w_adv & w_hz & ~i_mem_branch_taken;
  // HALT only counts once it is certain to leave ID this cycle.
  assign w_halt_go = i_id_halt_inst & ~w_hz & ~i_mem_branch_taken;

  // Front-end is frozen while draining; stalls hold PC and IF/ID.
  assign o_pipe_enb     = w_adv;
  assign o_pc_enb       = w_adv & ~w_stall & ~w_drain;
  assign o_if_id_enb    = w_adv & ~w_stall & ~w_drain;
  assign o_id_ex_bubble = w_stall;
  assign o_flush_if_id  = w_branch | w_drain;
  assign o_flush_id_ex  = w_branch;
  assign o_flush_ex_mem = w_branch;

  assign o_state       = r_state;
  assign o_halted      = r_halted;
  assign o_cycle_count = r_cycle_count;

  // Sequencer state machine, drain bookkeeping and saturating cycle counter.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_IDLE;
      r_halted      <= 1'b0;
      r_cycle_count <= '0;
      r_drain_cnt   <= '0;
      r_resume_run  <= 1'b0;
    end else begin
      if (w_adv && (r_cycle_count != {NB_CYCLE_CNT{1'b1}}))
        r_cycle_count <= r_cycle_count + 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (!r_halted && !i_halt_req) begin
            if (i_step)
              r_state <= ST_STEP;
            else if (i_run)
              r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (i_halt_req) begin
            r_state <= ST_IDLE;
          end else if (w_halt_go) begin
            r_state      <= ST_DRAIN;
            r_resume_run <= 1'b1;
            r_drain_cnt  <= NB_DRAIN'(DRAIN_CYCLES - 1);
          end
        end
        ST_STEP: begin
          if (w_halt_go) begin
            r_state      <= ST_DRAIN;
            r_resume_run <= 1'b0;
            r_drain_cnt  <= NB_DRAIN'(DRAIN_CYCLES - 1);
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          // A taken branch while draining means the HALT was speculative.
          if (i_mem_branch_taken) begin
            r_state  <= r_resume_run ? ST_RUN : ST_IDLE;
            r_halted <= 1'b0;
          end else if (r_drain_cnt == '0) begin
            r_state  <= ST_IDLE;
            r_halted <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Central run/step/halt controller and hazard sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Generates the advance enables for the PC and the pipeline latches.
- Inserts load-use bubbles into ID/EX and flushes the wrong-path stages when a branch resolves taken in MEM.
- On a HALT instruction, drains the pipeline. Counts executed cycles for the debug interface.

Parameters:
- NB_ADDR, 5, register-file address width
- NB_CYCLE_CNT, 32, cycle counter width
- NB_DRAIN, 2, drain counter width
- DRAIN_CYCLES, 3, cycles needed to empty EX/MEM/WB after HALT leaves ID

Ports:
- i_clock  in  1  system clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_run  in  1  debug pulse: enter free-running mode
- i_step  in  1  debug pulse: advance the pipeline exactly one cycle
- i_halt_req  in  1  debug pulse: pause (freeze) without drain
- i_id_halt_inst  in  1  ID stage decodes a HALT opcode
- i_id_rs_addr  in  NB_ADDR  rs address of the instruction in ID
- i_id_rt_addr  in  NB_ADDR  rt address of the instruction in ID
- i_id_uses_rt  in  1  instruction in ID reads rt
- i_ex_data_mem_rd_enb  in  1  instruction in EX is a load
- i_ex_rf_wr_addr  in  NB_ADDR  destination register of the instruction in EX
- i_mem_branch_taken  in  1  branch in MEM resolved taken (is_branch & zero)
- o_pc_enb  out  1  PC update enable
- o_if_id_enb  out  1  IF/ID latch enable
- o_pipe_enb  out  1  ID/EX, EX/MEM and MEM/WB latch enable
- o_id_ex_bubble  out  1  load NOP controls into ID/EX
- o_flush_if_id  out  1  clear IF/ID on the next edge
- o_flush_id_ex  out  1  clear ID/EX on the next edge
- o_flush_ex_mem  out  1  clear EX/MEM on the next edge
- o_state  out  2  current state encoding
- o_halted  out  1  program finished via HALT
- o_cycle_count  out  NB_CYCLE_CNT  cycles with o_pipe_enb=1

Behaviour:
- States: IDLE=00, RUN=01, STEP=10, DRAIN=11.
- Reset (async, i_reset_n=0):
  - state=IDLE, o_halted=0, o_cycle_count=0, drain_cnt=0, resume_run=0.
  - All combinational outputs are therefore 0.
- adv = (state != IDLE).
- o_pipe_enb = adv.
- Load-use hazard (combinational), hz = i_ex_data_mem_rd_enb & (i_ex_rf_wr_addr != 0) & ((i_ex_rf_wr_addr == i_id_rs_addr) | (i_id_uses_rt & i_ex_rf_wr_addr == i_id_rt_addr)).
- Branch flush (priority over hazard), when adv & i_mem_branch_taken:
  - o_flush_if_id = o_flush_id_ex = o_flush_ex_mem = 1.
  - o_pc_enb = 1, o_if_id_enb = 1, o_id_ex_bubble = 0.
- Stall, when adv & hz & !branch: o_pc_enb = 0, o_if_id_enb = 0, o_id_ex_bubble = 1. Latency is exactly one bubble per hazard.
- Normal, when adv & !hz & !branch: o_pc_enb = o_if_id_enb = 1.
- In DRAIN: o_pc_enb = 0 and o_if_id_enb = 0 always. o_flush_if_id = 1 on every DRAIN cycle.
- Transitions:
  - IDLE: if o_halted, stay (only reset exits). Else priority i_halt_req > i_step > i_run; step → STEP, run → RUN.
  - RUN: i_halt_req → IDLE. Else, if i_id_halt_inst & !hz & !branch → DRAIN with resume_run=1 and drain_cnt=DRAIN_CYCLES-1. i_run/i_step are ignored.
  - STEP: lasts exactly one cycle. HALT is detected as in RUN → DRAIN with resume_run=0. Else → IDLE.
  - DRAIN: drain_cnt decrements each cycle. At 0 → IDLE with o_halted=1.
  - DRAIN exit on branch: i_mem_branch_taken in DRAIN means the HALT was on the wrong path. Abort to RUN if resume_run, else IDLE, with o_halted=0. i_halt_req and i_id_halt_inst are ignored in DRAIN.
- o_cycle_count increments when o_pipe_enb=1 and saturates at all-ones.
- A reset asserted mid-DRAIN or mid-stall returns to the reset values immediately.

Decomposition:
- Shared package pipeline_pkg holds:
  - state encodings ST_IDLE, ST_RUN, ST_STEP, ST_DRAIN;
  - DRAIN_CYCLES;
  - the HALT opcode constant;
  - the register-zero address constant.
- One natural sub-module, load_use_detector: purely combinational computation of hz from the ID/EX address ports.

Test Plan:
- Reset then i_run pulse → o_state 01 next cycle. o_pc_enb = o_if_id_enb = o_pipe_enb = 1. o_cycle_count reaches 10 after 10 cycles.
- RUN with ex load to r5 and ID rs=5 → one cycle of o_pc_enb=0, o_if_id_enb=0, o_id_ex_bubble=1, then normal. Same case with ex write to r0 → no stall.
- RUN with hz=1 and i_mem_branch_taken=1 in the same cycle → all three flushes = 1, o_pc_enb=1, o_id_ex_bubble=0.
- IDLE with i_step pulse → exactly one cycle of o_pipe_enb=1, then IDLE. o_cycle_count increments by 1. i_run+i_step together → STEP.
- RUN with i_id_halt_inst → 3 DRAIN cycles with o_pc_enb=0, then o_halted=1 and IDLE. A later i_run is ignored.
- DRAIN second cycle with i_mem_branch_taken=1 → back to RUN with o_halted=0. i_reset_n low mid-DRAIN → immediate IDLE, count=0.
